mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Purpose  : MEM-stage data-memory handshake controller. It latches an
//             aligned load/store from EX/MEM, holds a request until the memory
//             acknowledges it, and stalls the pipeline while the access is
//             outstanding. Misaligned accesses raise a one-cycle error pulse.
//  Options  : MEM_TIMEOUT_EN - abort an unacknowledged access after 16 REQ
//             cycles with an error pulse (and a zero load result).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] Wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] Rdata_o,
    output logic        stall_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        w_req;
    logic        w_aligned;

    assign w_req     = MemRead_i | MemWrite_i;
    assign w_aligned = (Addr_i[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
    // Value of the no-ack counter during the 16th unacknowledged REQ cycle.
    localparam logic [7:0] TMO_LAST = 8'd15;
    logic [7:0] tmo_cnt_q;
`endif

    // Stall must drop during reset so the pipeline can flush.
    always_comb begin
        stall_o = 1'b0;
        if (!rst_i) begin
            stall_o = ((state_q == S_IDLE) && w_req && w_aligned) ||
                      (state_q == S_REQ);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q   <= 8'd0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_aligned) begin
                            mem_addr_q  <= Addr_i;
                            mem_wdata_q <= Wdata_i;
                            mem_we_q    <= MemWrite_i;
                            mem_req_q   <= 1'b1;
                            state_q     <= S_REQ;
`ifdef MEM_TIMEOUT_EN
                            tmo_cnt_q   <= 8'd0;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_DONE;
                        if (!mem_we_q) begin
                            rdata_q <= mem_rdata_i;
                        end
`ifdef MEM_TIMEOUT_EN
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= S_DONE;
                        if (!mem_we_q) begin
                            rdata_q <= 32'd0;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
`endif
                    end
                end
                // One dead cycle lets EX/MEM advance past the finished access.
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign Rdata_o     = rdata_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_ctrl
//  Purpose  : Self-checking bench for mem_access_ctrl (table vectors, reset
//             sequences, randomized accesses against a transaction model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] Addr_i;
    logic [31:0] Wdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] Rdata_o;
    logic        stall_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    mem_access_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .Addr_i      (Addr_i),
        .Wdata_i     (Wdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .Rdata_o     (Rdata_o),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int          stalls;
        int          req_cycles;
        int          errs;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata_done;
        logic [31:0] rdata_after;
        logic        stable;
        logic        err_done;
        logic        req_after;
        logic        in_after;
        logic        finished;
    } res_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        int          exp_stalls;
        logic        exp_we;
        int          exp_errs;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1, idle again.
    // delay < 0 means the memory never acknowledges.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int delay,
                              input logic [31:0] rdata, output res_t r);
        logic misal;
        int   cyc;
        r = '{stalls: 0, req_cycles: 0, errs: 0, we: 1'b0, addr: 32'd0, wdata: 32'd0,
              rdata_done: 32'd0, rdata_after: 32'd0, stable: 1'b1, err_done: 1'b0,
              req_after: 1'b0, in_after: 1'b0, finished: 1'b0};
        misal      = (addr[1:0] != 2'b00);
        MemRead_i  = rd;
        MemWrite_i = wr;
        Addr_i     = addr;
        Wdata_i    = wdata;
        mem_ack_i  = 1'b0;
        cyc        = 0;
        while (!r.finished && cyc < 80) begin
            #4;
            r.stalls += int'(stall_o);
            r.errs   += int'(err_o);
            mem_ack_i = 1'b0;
            if (misal) begin
                if (mem_req_o) r.req_cycles++;
                if (cyc == 1) r.rdata_done = Rdata_o;
                if (cyc == 2) begin
                    r.rdata_after = Rdata_o;
                    r.finished    = 1'b1;
                end
            end else if (r.in_after) begin
                r.req_after   = mem_req_o;
                r.rdata_after = Rdata_o;
                r.finished    = 1'b1;
            end else if (mem_req_o) begin
                if (r.req_cycles == 0) begin
                    r.we    = mem_we_o;
                    r.addr  = mem_addr_o;
                    r.wdata = mem_wdata_o;
                end else if (mem_we_o !== r.we || mem_addr_o !== r.addr ||
                             mem_wdata_o !== r.wdata) begin
                    r.stable = 1'b0;
                end
                if (r.req_cycles == delay) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = rdata;
                end else begin
                    mem_rdata_i = $urandom;
                end
                r.req_cycles++;
            end else if (r.req_cycles > 0) begin
                // Completion cycle: a stray ack here must be ignored.
                r.rdata_done = Rdata_o;
                r.err_done   = err_o;
                r.in_after   = 1'b1;
                mem_ack_i    = 1'b1;
                mem_rdata_i  = ~rdata;
            end
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
            if (misal || r.in_after) begin
                MemRead_i  = 1'b0;
                MemWrite_i = 1'b0;
            end
            cyc++;
        end
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
    endtask

    task automatic check_result(input string tag, input res_t r, input logic [31:0] addr,
                                input logic [31:0] wdata, input int exp_stalls,
                                input int exp_req, input int exp_errs, input logic exp_we,
                                input logic exp_err_done, input logic [31:0] exp_rd);
        chk({tag, ".finished"}, 32'(r.finished), 32'd1);
        chk({tag, ".stalls"},   32'(r.stalls),   32'(exp_stalls));
        chk({tag, ".req_cyc"},  32'(r.req_cycles), 32'(exp_req));
        chk({tag, ".errs"},     32'(r.errs),     32'(exp_errs));
        chk({tag, ".rdata"},    r.rdata_done,    exp_rd);
        chk({tag, ".rdata_hold"}, r.rdata_after, exp_rd);
        if (addr[1:0] == 2'b00) begin
            chk({tag, ".we"},       32'(r.we),       32'(exp_we));
            chk({tag, ".addr"},     r.addr,          addr);
            chk({tag, ".wdata"},    r.wdata,         wdata);
            chk({tag, ".stable"},   32'(r.stable),   32'd1);
            chk({tag, ".err_done"}, 32'(r.err_done), 32'(exp_err_done));
            chk({tag, ".req_after"}, 32'(r.req_after), 32'd0);
        end
    endtask

    initial begin
        res_t        r;
        logic [31:0] model_rd;
        logic        t_rd, t_wr;
        logic [31:0] t_addr, t_wdata, t_rdata;
        int          t_delay;

        //            rd    wr    addr          wdata          dly rdata          stl we   err exp Rdata_o
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 2, 32'h1234_5678, 4, 1'b0, 0, 32'h1234_5678};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 0, 32'hDEAD_BEEF, 2, 1'b1, 0, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0042, 32'h0000_0000, 0, 32'h0BAD_0BAD, 0, 1'b0, 1, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0010, 32'h55AA_55AA, 1, 32'hFFFF_FFFF, 3, 1'b1, 0, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0000_0000, 0, 32'hA5A5_0001, 2, 1'b0, 0, 32'hA5A5_0001};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0083, 32'h1111_2222, 0, 32'h0000_0000, 0, 1'b1, 1, 32'hA5A5_0001};

        // Reset with an aligned request present: stall must stay low.
        rst_i       = 1'b1;
        MemRead_i   = 1'b1;
        MemWrite_i  = 1'b0;
        Addr_i      = 32'h0000_0040;
        Wdata_i     = 32'h0000_0000;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        #4;
        chk("reset.stall",   32'(stall_o),   32'd0);
        chk("reset.req",     32'(mem_req_o), 32'd0);
        chk("reset.we",      32'(mem_we_o),  32'd0);
        chk("reset.addr",    mem_addr_o,     32'd0);
        chk("reset.wdata",   mem_wdata_o,    32'd0);
        chk("reset.rdata",   Rdata_o,        32'd0);
        chk("reset.err",     32'(err_o),     32'd0);
        @(posedge clk_i); #1;
        rst_i     = 1'b0;
        MemRead_i = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                       vecs[i].delay, vecs[i].rdata, r);
            check_result($sformatf("vec%0d", i), r, vecs[i].addr, vecs[i].wdata,
                         vecs[i].exp_stalls,
                         (vecs[i].addr[1:0] == 2'b00) ? vecs[i].delay + 1 : 0,
                         vecs[i].exp_errs, vecs[i].exp_we, 1'b0, vecs[i].exp_rd);
        end

        // Reset in the second REQ cycle, then a late ack that must be ignored.
        MemRead_i = 1'b1;
        Addr_i    = 32'h0000_0020;
        #4;
        chk("rstreq.accept_stall", 32'(stall_o), 32'd1);
        @(posedge clk_i); #1;
        #4;
        chk("rstreq.req1", 32'(mem_req_o), 32'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #4;
        chk("rstreq.stall_in_rst", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i       = 1'b0;
        MemRead_i   = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0000_0099;
        #4;
        chk("rstreq.req_dropped", 32'(mem_req_o), 32'd0);
        chk("rstreq.rdata_clr",   Rdata_o,        32'd0);
        chk("rstreq.stall",       32'(stall_o),   32'd0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        #4;
        chk("rstreq.late_ack_req", 32'(mem_req_o), 32'd0);
        chk("rstreq.late_ack_rd",  Rdata_o,        32'd0);
        chk("rstreq.late_ack_err", 32'(err_o),     32'd0);
        @(posedge clk_i); #1;

        // Randomized accesses; the model only tracks the last completed load.
        model_rd = 32'd0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = $urandom;
                #4;
                chk($sformatf("rnd%0d.idle_req", n), 32'(mem_req_o), 32'd0);
                @(posedge clk_i); #1;
                mem_ack_i = 1'b0;
                #4;
                chk($sformatf("rnd%0d.idle_rd", n), Rdata_o, model_rd);
                @(posedge clk_i); #1;
            end
            case ($urandom_range(0, 2))
                0:       begin t_rd = 1'b1; t_wr = 1'b0; end
                1:       begin t_rd = 1'b0; t_wr = 1'b1; end
                default: begin t_rd = 1'b1; t_wr = 1'b1; end
            endcase
            t_addr = $urandom;
            if ($urandom_range(0, 3) != 0) t_addr[1:0] = 2'b00;
            t_wdata = $urandom;
            t_rdata = $urandom;
            t_delay = $urandom_range(0, 4);
            run_access(t_rd, t_wr, t_addr, t_wdata, t_delay, t_rdata, r);
            if (t_addr[1:0] == 2'b00) begin
                if (t_rd && !t_wr) model_rd = t_rdata;
                check_result($sformatf("rnd%0d", n), r, t_addr, t_wdata, t_delay + 2,
                             t_delay + 1, 0, t_wr, 1'b0, model_rd);
            end else begin
                check_result($sformatf("rnd%0d", n), r, t_addr, t_wdata, 0, 0, 1,
                             t_wr, 1'b0, model_rd);
            end
        end

`ifdef MEM_TIMEOUT_EN
        // Unacknowledged read: 16 REQ cycles, then DONE with error and zero data.
        run_access(1'b1, 1'b0, 32'h0000_0060, 32'h0, -1, 32'h0, r);
        check_result("timeout", r, 32'h0000_0060, 32'h0, 17, 16, 1, 1'b0, 1'b1, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
